// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 red/green frame store with frame-synchronous swap and multi-cycle back-buffer clear.
// Optional FB_COPY_ON_SWAP_EN: on swap, the new back buffer is also loaded with the newly displayed frame.
module led_frame_buffer (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            frame_tick,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [2:0]      wr_col,
  input  logic [1:0]      wr_color,
  input  logic            clear_req,
  input  logic            swap_req,
  output logic            ready,
  output logic            swap_done,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array
);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t          state, state_nxt;
  logic            front;
  logic [2:0]      clr_row;
  logic [7:0][7:0] red_a, green_a, red_b, green_b;
  logic            do_write, do_clear, do_swap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_clear  = 1'b0;
    do_swap   = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
        end else begin
          // a write alongside a swap request still lands before the swap
          if (swap_req) state_nxt = SWAP_WAIT;
          do_write = wr_en;
        end
      end
      CLEAR: begin
        do_clear = 1'b1;
        if (clr_row == 3'd7) state_nxt = IDLE;
      end
      SWAP_WAIT: begin
        if (frame_tick) begin
          do_swap   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      red_a     <= '0;
      green_a   <= '0;
      red_b     <= '0;
      green_b   <= '0;
      front     <= 1'b0;
      clr_row   <= '0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        front <= ~front;
`ifdef FB_COPY_ON_SWAP_EN
        if (front) begin
          red_b   <= red_a;
          green_b <= green_a;
        end else begin
          red_a   <= red_b;
          green_a <= green_b;
        end
`endif
      end
      if (do_write) begin
        if (front) begin
          red_a[wr_row][wr_col]   <= wr_color[0];
          green_a[wr_row][wr_col] <= wr_color[1];
        end else begin
          red_b[wr_row][wr_col]   <= wr_color[0];
          green_b[wr_row][wr_col] <= wr_color[1];
        end
      end
      if (do_clear) begin
        if (front) begin
          red_a[clr_row]   <= '0;
          green_a[clr_row] <= '0;
        end else begin
          red_b[clr_row]   <= '0;
          green_b[clr_row] <= '0;
        end
        clr_row <= clr_row + 3'd1;
      end
    end
  end

  // front bank changes only on swap edges, so the displayed frame is always complete
  assign red_array   = front ? red_b   : red_a;
  assign green_array = front ? green_b : green_a;

endmodule
